stack_alu_sequencer: RTL and testbench

//  Program sequencer that sits directly upstream of the stack-based ALU and drives its opcode/data inputs.

---
 rtl/stack_alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stack_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_sequencer.sv
// Program sequencer driving a stack ALU: loadable opcode/immediate memory, one issue per cycle,
// 2-cycle result capture, sticky overflow, and abort on stack under/overflow via a shadow depth.
module stack_alu_sequencer #(
  parameter int unsigned N           = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [2:0]    load_op,
  input  logic [N-1:0]  load_data,
  input  logic          start,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_data,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          result_valid,
  output logic          ovf_sticky,
  output logic          err
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [2:0]    alu_opcode_q;
  logic [N-1:0]  alu_data_q;
  logic          busy_q, done_q, result_valid_q, ovf_sticky_q, err_q;
  logic [N-1:0]  result_q;
  logic          res_op_q, res_arith_q;

  logic [2:0]    mem_op   [DEPTH];
  logic [N-1:0]  mem_data [DEPTH];

  logic [2:0]    cur_op;
  logic [N-1:0]  cur_data;
  logic          is_push, is_arith, is_pop, illegal, last_entry;

  // Program memory: no reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (load_en && state_q == S_IDLE) begin
      mem_op[load_addr]   <= load_op;
      mem_data[load_addr] <= load_data;
    end
  end

  // Current-instruction decode and legality against the shadow stack depth.
  always_comb begin
    cur_op     = mem_op[pc_q];
    cur_data   = mem_data[pc_q];
    is_push    = (cur_op == OP_PUSH);
    is_arith   = (cur_op == OP_ADD) || (cur_op == OP_MUL);
    is_pop     = (cur_op == OP_POP);
    illegal    = (is_push  && depth_q >= DW'(STACK_DEPTH)) ||
                 (is_arith && depth_q <  DW'(2)) ||
                 (is_pop   && depth_q == '0);
    last_entry = (pc_q == AW'(DEPTH - 1));
    pc_d       = pc_q + AW'(1);
    depth_d    = depth_q;
    if (is_push) begin
      depth_d = depth_q + DW'(1);
    end else if (is_arith || is_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      depth_q        <= '0;
      alu_opcode_q   <= OP_HALT;
      alu_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_sticky_q   <= 1'b0;
      err_q          <= 1'b0;
      res_op_q       <= 1'b0;
      res_arith_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      alu_opcode_q <= OP_HALT;

      // Result pipeline: opcode on the bus executes this edge, its output is sampled next edge.
      res_op_q       <= (alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_MUL) || (alu_opcode_q == OP_POP);
      res_arith_q    <= (alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_MUL);
      result_valid_q <= res_op_q;
      if (res_op_q) begin
        result_q <= alu_result;
      end
      if (res_arith_q) begin
        ovf_sticky_q <= ovf_sticky_q | alu_overflow;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RUN;
            pc_q         <= '0;
            depth_q      <= '0;
            ovf_sticky_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        S_RUN: begin
          if (illegal) begin
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end else if (cur_op == OP_HALT) begin
            state_q <= S_DRAIN;
          end else begin
            if (is_push || is_arith || is_pop) begin
              alu_opcode_q <= cur_op;
              alu_data_q   <= cur_data;
            end
            depth_q <= depth_d;
            pc_q    <= pc_d;
            if (last_entry) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_data     = alu_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovf_sticky   = ovf_sticky_q;
  assign err          = err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU, queue-based program reference model,
// directed scenarios plus random programs, cycle-exact output comparison.
module tb_stack_alu_sequencer;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned SD    = 16;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_NOP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [2:0]    load_op = '0;
  logic [N-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result;
  logic          alu_overflow;
  logic          busy, done, result_valid, ovf_sticky, err;
  logic [N-1:0]  result;

  int checks = 0;
  int failures = 0;

  logic [2:0]   prog_op   [DEPTH];
  logic [N-1:0] prog_data [DEPTH];

  int           exp_R, exp_nres;
  logic         exp_err, exp_ovf;
  logic [2:0]   exp_op_at  [64];
  logic         exp_rv_at  [64];
  logic [N-1:0] exp_res_at [64];

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_op(load_op),
    .load_data(load_data), .start(start), .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid), .ovf_sticky(ovf_sticky), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int alu_calc(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (op == OP_ADD) ? sa + sb : sa * sb;
  endfunction

  // Behavioural stack ALU: output registered at the edge where the opcode executes.
  logic [N-1:0] astk [64];
  logic [5:0]   asp;
  always @(posedge clk) begin
    if (rst) begin
      asp          <= '0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else if (alu_opcode == OP_PUSH && asp < 6'd63) begin
      astk[asp] <= alu_data;
      asp       <= asp + 6'd1;
    end else if ((alu_opcode == OP_ADD || alu_opcode == OP_MUL) && asp >= 6'd2) begin
      astk[asp - 6'd2] <= N'(alu_calc(alu_opcode, astk[asp - 6'd2], astk[asp - 6'd1]));
      alu_result       <= N'(alu_calc(alu_opcode, astk[asp - 6'd2], astk[asp - 6'd1]));
      alu_overflow     <= (alu_calc(alu_opcode, astk[asp - 6'd2], astk[asp - 6'd1]) > 127) ||
                          (alu_calc(alu_opcode, astk[asp - 6'd2], astk[asp - 6'd1]) < -128);
      asp              <= asp - 6'd1;
    end else if (alu_opcode == OP_POP && asp >= 6'd1) begin
      alu_result   <= astk[asp - 6'd1];
      alu_overflow <= 1'b0;
      asp          <= asp - 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk the program with a value stack; entry j appears on the bus in cycle j+2
  // after start, its result in cycle j+4; done in cycle R+2 where R = entries consumed.
  task automatic model();
    int   stk[$];
    int   a, b, r;
    byte  v;
    logic [2:0] op;
    exp_R = 0; exp_err = 1'b0; exp_ovf = 1'b0; exp_nres = 0;
    for (int c = 0; c < 64; c++) begin
      exp_op_at[c] = OP_HALT; exp_rv_at[c] = 1'b0; exp_res_at[c] = '0;
    end
    for (int j = 0; j < int'(DEPTH); j++) begin
      op = prog_op[j];
      exp_R = j + 1;
      if (op == OP_HALT) break;
      if (op == OP_PUSH) begin
        if (stk.size() >= int'(SD)) begin exp_err = 1'b1; break; end
        stk.push_back(int'($signed(prog_data[j])));
        exp_op_at[j+2] = op;
      end else if (op == OP_ADD || op == OP_MUL) begin
        if (stk.size() < 2) begin exp_err = 1'b1; break; end
        b = stk.pop_back();
        a = stk.pop_back();
        r = (op == OP_ADD) ? a + b : a * b;
        v = 8'(r);
        if (int'(v) != r) exp_ovf = 1'b1;
        stk.push_back(int'(v));
        exp_op_at[j+2] = op;
        exp_rv_at[j+4] = 1'b1; exp_res_at[j+4] = 8'(v); exp_nres++;
      end else if (op == OP_POP) begin
        if (stk.size() < 1) begin exp_err = 1'b1; break; end
        v = 8'(stk.pop_back());
        exp_op_at[j+2] = op;
        exp_rv_at[j+4] = 1'b1; exp_res_at[j+4] = 8'(v); exp_nres++;
      end
    end
  endtask

  task automatic load_prog();
    for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(i); load_op = prog_op[i]; load_data = prog_data[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_op[i] = OP_HALT; prog_data[i] = '0;
    end
  endtask

  // Start a run (optionally writing entry 0 in the start cycle) and check every cycle.
  task automatic exec(input bit load0, input bit disturb, input string tag);
    int nres, ndone;
    model();
    nres = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    if (load0) begin
      load_en = 1'b1; load_addr = '0; load_op = prog_op[0]; load_data = prog_data[0];
    end
    for (int c = 1; c <= exp_R + 6; c++) begin
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      if (disturb && c == 3) begin
        start = 1'b1; load_en = 1'b1;
        load_addr = AW'(DEPTH - 1); load_op = OP_HALT; load_data = 8'hAA;
      end
      chk({tag, " opcode"}, 32'(alu_opcode), 32'(exp_op_at[c]));
      chk({tag, " busy"}, 32'(busy), 32'(c <= exp_R + 1));
      chk({tag, " done"}, 32'(done), 32'(c == exp_R + 2));
      chk({tag, " result_valid"}, 32'(result_valid), 32'(exp_rv_at[c]));
      if (exp_rv_at[c]) chk({tag, " result"}, 32'(result), 32'(exp_res_at[c]));
      if (result_valid) nres++;
      if (done) ndone++;
    end
    chk({tag, " result count"}, 32'(nres), 32'(exp_nres));
    chk({tag, " done count"}, 32'(ndone), 32'd1);
    chk({tag, " ovf_sticky"}, 32'(ovf_sticky), 32'(exp_ovf));
    chk({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int r;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset alu_opcode", 32'(alu_opcode), 32'd0);
    chk("reset alu_data", 32'(alu_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset ovf_sticky", 32'(ovf_sticky), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    // T1: push 10, push -20, add, push 30, mul, pop, halt
    clear_prog();
    prog_op[0] = OP_PUSH; prog_data[0] = 8'd10;
    prog_op[1] = OP_PUSH; prog_data[1] = 8'hEC;
    prog_op[2] = OP_ADD;
    prog_op[3] = OP_PUSH; prog_data[3] = 8'd30;
    prog_op[4] = OP_MUL;
    prog_op[5] = OP_POP;
    load_prog();
    exec(1'b1, 1'b0, "t1");
    chk("t1 final result", 32'(result), 32'hD4);
    chk("t1 ovf", 32'(ovf_sticky), 32'd1);

    // T2: add on empty stack
    clear_prog();
    prog_op[0] = OP_ADD;
    prog_op[1] = OP_PUSH; prog_data[1] = 8'd5;
    load_prog();
    exec(1'b1, 1'b0, "t2");
    chk("t2 err", 32'(err), 32'd1);

    // T3: 17 pushes, 17th exceeds stack capacity
    clear_prog();
    for (int i = 0; i < 17; i++) begin prog_op[i] = OP_PUSH; prog_data[i] = 8'd1; end
    load_prog();
    exec(1'b1, 1'b0, "t3");
    chk("t3 err", 32'(err), 32'd1);

    // T4: full program of push/pop pairs, no halt
    clear_prog();
    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_op[i] = (i % 2 == 0) ? OP_PUSH : OP_POP; prog_data[i] = 8'(i * 7 + 3);
    end
    load_prog();
    exec(1'b1, 1'b0, "t4");
    chk("t4 result count", 32'(exp_nres), 32'd16);

    // T5: rst mid-run, then rerun from retained memory
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 opcode before rst", 32'(alu_opcode != OP_HALT), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 rst opcode", 32'(alu_opcode), 32'd0);
    chk("t5 rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exec(1'b0, 1'b0, "t5");

    // T6: start and load_en while busy are ignored
    exec(1'b0, 1'b1, "t6");
    exec(1'b0, 1'b0, "t6 rerun");

    // Random programs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r = int'($urandom_range(0, 99));
        prog_data[i] = 8'($urandom);
        if (r < 40)      prog_op[i] = OP_PUSH;
        else if (r < 55) prog_op[i] = OP_ADD;
        else if (r < 68) prog_op[i] = OP_MUL;
        else if (r < 84) prog_op[i] = OP_POP;
        else if (r < 96) prog_op[i] = 3'($urandom_range(1, 3));
        else             prog_op[i] = OP_HALT;
      end
      if (prog_op[0] == OP_HALT) prog_op[0] = OP_NOP;
      load_prog();
      exec(1'b1, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
